// File: rtl/noc_pkg.sv
// Shared types and constants for the NOC transmit serializer.
// Optional CRC trailer state exists only when NOC_TX_CRC_EN is defined.
package noc_pkg;

  localparam logic [7:0] NOC_NOP      = 8'h00;
  localparam logic [7:0] NOC_HDR_BYTE = 8'h22;

`ifdef NOC_TX_CRC_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CRC
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } tx_state_e;
`endif

  typedef struct packed {
    logic        first;
    logic [63:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/noc_tx_fifo.sv
// Word FIFO between the permutation core and the byte serializer.
// Reports occupancy and flags pushes that arrive while full.
module noc_tx_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  fifo_entry_t   wdata,
  output fifo_entry_t   rdata,
  output logic [CW-1:0] count,
  output logic          drop
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t         mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                pop_ok;
  logic                push_ok;
  logic                full;

  // A pop in the same cycle frees a slot, so a push at full still lands.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && (!full || pop_ok);
    drop     = push && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/noc_tx_serializer.sv
// Device-to-NOC transmit path: buffers 64-bit words, emits framed bytes.
// Define NOC_TX_CRC_EN to append an XOR check byte after each full frame.
module noc_tx_serializer
  import noc_pkg::*;
#(
  parameter int         WORDS_PER_FRAME = 25,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [7:0] HDR_BYTE        = NOC_HDR_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  output logic        noc_from_dev_ctl,
  output logic [7:0]  noc_from_dev_data,
  output logic        tx_err
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  tx_state_e        state_q, state_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic             ctl_q, ctl_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;
  logic             proto_err;
  logic             pop;
  logic             head_vld;
  fifo_entry_t      head;
  fifo_entry_t      wentry;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_drop;
`ifdef NOC_TX_CRC_EN
  logic [7:0]       crc_q, crc_d;
`endif

  assign wentry.first = firstout;
  assign wentry.data  = dout;

  noc_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushout),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_cnt),
    .drop  (fifo_drop)
  );

  assign head_vld = (fifo_cnt != '0);
  assign stopout  = (fifo_cnt >= CW'(FIFO_DEPTH - 1));

  // Frame FSM: picks the next output byte and advances word/byte position.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    ctl_d      = 1'b1;
    data_d     = NOC_NOP;
    proto_err  = 1'b0;
    pop        = 1'b0;
`ifdef NOC_TX_CRC_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (head_vld) begin
          if (head.first) begin
            state_d = ST_HDR;
          end else begin
            pop       = 1'b1;
            proto_err = 1'b1;
          end
        end
      end
      ST_HDR: begin
        data_d     = HDR_BYTE;
        byte_idx_d = '0;
        word_cnt_d = '0;
`ifdef NOC_TX_CRC_EN
        crc_d      = '0;
`endif
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (head_vld) begin
          if (byte_idx_q == 3'd0 && word_cnt_q != '0 && head.first) begin
            proto_err = 1'b1;
            state_d   = ST_HDR;
          end else begin
            ctl_d      = 1'b0;
            data_d     = head.data[{byte_idx_q, 3'b000} +: 8];
            byte_idx_d = byte_idx_q + 3'd1;
`ifdef NOC_TX_CRC_EN
            crc_d      = crc_q ^ data_d;
`endif
            if (byte_idx_q == 3'd7) begin
              pop        = 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
              if (word_cnt_q == WCW'(WORDS_PER_FRAME - 1)) begin
`ifdef NOC_TX_CRC_EN
                state_d = ST_CRC;
`else
                state_d = ST_IDLE;
`endif
              end
            end
          end
        end
      end
`ifdef NOC_TX_CRC_EN
      ST_CRC: begin
        ctl_d   = 1'b0;
        data_d  = crc_q;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error collects FSM protocol errors and FIFO overflow drops.
  assign err_d = err_q | proto_err | fifo_drop;

  // State, counters and registered NOC outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      ctl_q      <= 1'b1;
      data_q     <= NOC_NOP;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      ctl_q      <= ctl_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

`ifdef NOC_TX_CRC_EN
  // Running XOR of the data bytes of the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end
`endif

  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign tx_err            = err_q;

endmodule

// File: tb/tb_noc_tx_serializer.sv
// Self-checking bench for noc_tx_serializer (2-word frames, 4-deep FIFO).
// Builds expectations from frame rules; honours NOC_TX_CRC_EN if defined.
module tb_noc_tx_serializer;

  localparam int WPF   = 2;
  localparam int DEPTH = 4;
  localparam logic [8:0] NOP_T = 9'h100;
  localparam logic [8:0] HDR_T = 9'h122;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushout = 1'b0;
  logic        firstout = 1'b0;
  logic [63:0] dout = '0;
  logic        stopout;
  logic        ctl;
  logic [7:0]  data;
  logic        err;

  noc_tx_serializer #(
    .WORDS_PER_FRAME (WPF),
    .FIFO_DEPTH      (DEPTH),
    .HDR_BYTE        (8'h22)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pushout           (pushout),
    .firstout          (firstout),
    .dout              (dout),
    .stopout           (stopout),
    .noc_from_dev_ctl  (ctl),
    .noc_from_dev_data (data),
    .tx_err            (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] got_q[$];
  logic [8:0] all_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] prev_tok = NOP_T;
  int hdr_gap_bad = 0;

  typedef struct {
    logic        push;
    logic        first;
    logic [63:0] d;
    logic [8:0]  exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, pass the edge, sample 1ns later.
  task automatic tick(input logic p, input logic f, input logic [63:0] d);
    logic [8:0] tok;
    pushout  = p;
    firstout = f;
    dout     = d;
    @(posedge clk);
    #1;
    pushout  = 1'b0;
    firstout = 1'b0;
    tok = {ctl, data};
    all_q.push_back(tok);
    if (tok != NOP_T) got_q.push_back(tok);
    if (tok == HDR_T && prev_tok != NOP_T) hdr_gap_bad++;
    prev_tok = tok;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
  endtask

  task automatic clear_q();
    got_q.delete();
    all_q.delete();
    exp_q.delete();
    prev_tok = NOP_T;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
  endtask

  // Expected tokens of a complete frame: header, bytes LSB first, check byte.
  task automatic add_frame(input logic [63:0] w0, input logic [63:0] w1);
    logic [63:0] w;
    logic [7:0]  x;
    x = 8'h00;
    exp_q.push_back(HDR_T);
    for (int k = 0; k < 16; k++) begin
      w = (k < 8) ? w0 : w1;
      exp_q.push_back({1'b0, w[8*(k%8) +: 8]});
      x = x ^ w[8*(k%8) +: 8];
    end
`ifdef NOC_TX_CRC_EN
    exp_q.push_back({1'b0, x});
`endif
  endtask

  task automatic add_trunc(input logic [63:0] w0);
    exp_q.push_back(HDR_T);
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, w0[8*k +: 8]});
  endtask

  task automatic cmp_stream(input string name);
    int n;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_tok"}, got_q[i], exp_q[i]);
  endtask

  logic [63:0] w0, w1, w2;
  logic [7:0]  x;
  logic [63:0] rw[$];
  logic        rf[$];
  int          idx, i8, i9, found;

  initial begin
    w0 = 64'h0807060504030201;
    w1 = 64'h100F0E0D0C0B0A09;
    w2 = 64'hA5A5_5A5A_0123_4567;

    // 1: reset state
    do_reset();
    chk("rst_stop", stopout, 1'b0);
    chk("rst_err", err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, '0);
      chk("rst_nop", {ctl, data}, NOP_T);
    end

    // 2: single frame, cycle-exact table
    clear_q();
    x = 8'h00;
    tbl.push_back('{1'b1, 1'b1, w0, NOP_T});
    tbl.push_back('{1'b1, 1'b0, w1, NOP_T});
    tbl.push_back('{1'b0, 1'b0, '0, HDR_T});
    for (int k = 0; k < 16; k++) begin
      logic [63:0] w;
      w = (k < 8) ? w0 : w1;
      x = x ^ w[8*(k%8) +: 8];
      tbl.push_back('{1'b0, 1'b0, '0, {1'b0, w[8*(k%8) +: 8]}});
    end
`ifdef NOC_TX_CRC_EN
    tbl.push_back('{1'b0, 1'b0, '0, {1'b0, x}});
`endif
    tbl.push_back('{1'b0, 1'b0, '0, NOP_T});
    tbl.push_back('{1'b0, 1'b0, '0, NOP_T});
    foreach (tbl[i]) begin
      tick(tbl[i].push, tbl[i].first, tbl[i].d);
      chk("t2_byte", {ctl, data}, tbl[i].exp);
    end
    chk("t2_err", err, 1'b0);

    // 3: burst of 5 ignoring stopout
    do_reset();
    tick(1'b1, 1'b1, w0);
    chk("t3_stop1", stopout, 1'b0);
    tick(1'b1, 1'b0, w1);
    chk("t3_stop2", stopout, 1'b0);
    tick(1'b1, 1'b0, w2);
    chk("t3_stop3", stopout, 1'b1);
    chk("t3_err3", err, 1'b0);
    tick(1'b1, 1'b0, w0);
    chk("t3_err4", err, 1'b0);
    tick(1'b1, 1'b0, w1);
    chk("t3_err5", err, 1'b1);

    // 4: underrun between word 0 and word 1
    do_reset();
    tick(1'b1, 1'b1, w0);
    idle(14);
    tick(1'b1, 1'b0, w1);
    idle(25);
    add_frame(w0, w1);
    cmp_stream("t4");
    i8 = -1;
    i9 = -1;
    foreach (all_q[i]) begin
      if (all_q[i] == 9'h008 && i8 < 0) i8 = i;
      if (all_q[i] == 9'h009 && i9 < 0) i9 = i;
    end
    chk("t4_gap", i9 - i8 - 1, 5);
    chk("t4_err", err, 1'b0);

    // 5: non-first word while idle
    do_reset();
    tick(1'b1, 1'b0, w2);
    idle(6);
    chk("t5_err", err, 1'b1);
    chk("t5_tokens", got_q.size(), 0);
    chk("t5_stop", stopout, 1'b0);

    // 6: truncation by an early first word
    do_reset();
    tick(1'b1, 1'b1, w0);
    tick(1'b1, 1'b1, w1);
    tick(1'b1, 1'b0, w2);
    idle(40);
    add_trunc(w0);
    add_frame(w1, w2);
    cmp_stream("t6");
    chk("t6_err", err, 1'b1);

    // 7: async reset in the middle of word 0
    do_reset();
    tick(1'b1, 1'b1, w0);
    tick(1'b1, 1'b0, w1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1'b0, 1'b0, '0);
      if ({ctl, data} == 9'h004) found = 1;
    end
    chk("t7_sync", found, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async", {ctl, data}, NOP_T);
    chk("t7_stop", stopout, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    idle(12);
    chk("t7_noresume", got_q.size(), 0);
    chk("t7_err", err, 1'b0);
    tick(1'b1, 1'b1, w2);
    tick(1'b1, 1'b0, w0);
    idle(30);
    add_frame(w2, w0);
    cmp_stream("t7");

    // Random frames, pushes gated by stopout, random gaps
    do_reset();
    hdr_gap_bad = 0;
    rw.delete();
    rf.delete();
    for (int f = 0; f < 30; f++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      rw.push_back(a);
      rf.push_back(1'b1);
      rw.push_back(b);
      rf.push_back(1'b0);
      add_frame(a, b);
    end
    idx = 0;
    for (int c = 0; c < 5000; c++) begin
      if (idx >= rw.size() && got_q.size() >= exp_q.size()) break;
      if (idx < rw.size() && !stopout && $urandom_range(0, 3) != 0) begin
        tick(1'b1, rf[idx], rw[idx]);
        idx++;
      end else begin
        tick(1'b0, 1'b0, '0);
      end
    end
    idle(4);
    chk("rnd_pushed", idx, rw.size());
    cmp_stream("rnd");
    chk("rnd_err", err, 1'b0);
    chk("rnd_hdr_gap", hdr_gap_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
